pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Sequential program-counter and front-end control for the RISC-V pipeline. It owns the PC register and redirects fetch on resolved jumps and taken branches from EX. It applies hazard stalls and runs the halt sequence: accept HALT in ID, squash younger work, drain the pipe, then freeze. It sits between instruction memory and the IF/ID, ID/EX pipeline registers, and consumes the decoded jump/branch/halt information produced upstream.

## Interface
- PC_W, 9: PC width in bits; PC wraps modulo 2^PC_W.
- RESET_PC, 0: PC value after reset; must be a multiple of 4.
- DRAIN_CYC, 3: cycles spent in DRAIN before `halted` rises; legal range 1..15.

- clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit request to hold PC and IF/ID.
- ex_redirect  in  1  EX resolved a jump (JAL/JALR) or a taken branch this cycle.
- ex_target  in  PC_W  redirect target address from EX.
- id_halt  in  1  instruction currently in ID decodes as HALT.
- pc  out  PC_W  current fetch address.
- fetch_en  out  1  instruction-memory fetch enable / IF/ID load enable.
- flush_ifid  out  1  squash IF/ID contents at the next edge.
- flush_idex  out  1  squash ID/EX contents at the next edge.
- halted  out  1  core has stopped; sticky until reset.
- misalign_err  out  1  sticky; a redirect target had bits [1:0] != 0.

## Operation
- States: RUN, DRAIN, HALTED. Reset → RUN with pc=RESET_PC, halted=0, misalign_err=0, drain counter=0, fetch_en=1, flush_ifid=0, flush_idex=0.
- RUN priority, highest first:
  - ex_redirect: pc ← {ex_target[PC_W-1:2],2'b00}. flush_ifid=1 and flush_idex=1 combinationally this cycle. Overrides stall and id_halt. If ex_target[1:0]!=0, set misalign_err.
  - stall: pc holds; fetch_en=0; no flushes; id_halt is not accepted (HALT remains in ID).
  - id_halt: accept HALT. pc holds and does not increment. flush_ifid=1 this cycle. Load counter with DRAIN_CYC and go to DRAIN.
  - otherwise: pc ← pc+4, truncated to PC_W (wraps from 2^PC_W−4 to 0).
- DRAIN: fetch_en=0, flush_ifid=1, flush_idex=0, pc holds. Counter decrements each cycle. When the counter reaches 1, go to HALTED at the next edge. ex_redirect, stall and id_halt are ignored, because only HALT and older instructions remain in flight.
- HALTED: fetch_en=0, halted=1, flush outputs 0, pc frozen at the HALT address. All inputs are ignored; only reset_n exits this state.
- Simultaneous ex_redirect and id_halt in RUN: the redirect wins and HALT is discarded as wrong-path. No DRAIN entry occurs.
- reset_n asserted in any state, including mid-DRAIN: immediate asynchronous return to reset values.

## Timing
- Redirect latency: ex_redirect high in cycle n → pc = target in cycle n+1. Flushes are high only in cycle n.
- Sequential fetch: one PC increment per unstalled RUN cycle.
- Halt: id_halt accepted in cycle n → DRAIN in cycles n+1..n+DRAIN_CYC → halted=1 from cycle n+DRAIN_CYC+1.
- fetch_en and the flush outputs are combinational from state and inputs. pc, halted and misalign_err are registered.
- Deassertion of reset_n is sampled at a rising edge. The first increment occurs at the first edge after release.

## Test plan
- Reset then 5 free-running cycles → pc sequence 0,4,8,12,16. fetch_en=1 throughout.
- Redirect at pc=0x10 with ex_target=0x40 while stall=1 → flush_ifid=flush_idex=1 that cycle; next pc=0x40; misalign_err=0. Repeat with ex_target=0x42 → pc=0x40, misalign_err=1 and sticky.
- stall high 3 cycles at pc=0x20 with id_halt=1 → pc holds at 0x20 and no DRAIN entry. Release stall → halt accepted; after DRAIN_CYC=3 cycles halted=1 and pc stays 0x20.
- ex_redirect and id_halt together at pc=0x30, target 0x08 → pc=0x08, state stays RUN, halted never asserts.
- PC_W=9, pc=0x1FC, free run → next pc=0x000.
- reset_n pulsed low during the second DRAIN cycle → outputs return to reset values immediately. After release pc runs 0,4,… and halted=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// ------------
// Program counter and front-end control for the RISC-V pipeline. Holds the
// fetch PC, redirects it on jumps/taken branches resolved in EX, applies
// hazard stalls, and runs the halt sequence:
//   1. Accept HALT in ID.
//   2. Squash younger work.
//   3. Drain the pipe for DRAIN_CYC cycles.
//   4. Freeze until reset.
//
// Parameters
//   PC_W       PC width in bits; the PC wraps modulo 2^PC_W.
//   RESET_PC   PC value after reset (multiple of 4).
//   DRAIN_CYC  cycles spent draining before halted rises (1..15).
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   stall         in   hazard unit: hold PC and IF/ID
//   ex_redirect   in   EX resolved a jump or taken branch this cycle
//   ex_target     in   redirect target from EX
//   id_halt       in   instruction in ID is HALT
//   pc            out  current fetch address (registered)
//   fetch_en      out  imem fetch enable / IF/ID load enable (combinational)
//   flush_ifid    out  squash IF/ID at the next edge (combinational)
//   flush_idex    out  squash ID/EX at the next edge (combinational)
//   halted        out  core stopped; sticky until reset (registered)
//   misalign_err  out  sticky: a redirect target had bits [1:0] != 0

module pc_sequencer #(
  parameter int PC_W      = 9,
  parameter int RESET_PC  = 0,
  parameter int DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  input  logic            id_halt,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            halted,
  output logic            misalign_err
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0]      DRAIN_LOAD = 4'(DRAIN_CYC);
  localparam logic [PC_W-1:0] PC_RESET   = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    halted_d   = halted_q;
    err_d      = err_q;
    fetch_en   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    case (state_q)
      ST_RUN: begin
        fetch_en = 1'b1;
        if (ex_redirect) begin
          // The redirect beats stall and a simultaneous HALT. A HALT in ID
          // that arrives with a redirect is on the wrong path, so it is
          // dropped together with the rest of IF/ID.
          pc_d       = {ex_target[PC_W-1:2], 2'b00};
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (ex_target[1:0] != 2'b00) begin
            err_d = 1'b1;
          end
        end else if (stall) begin
          // Hold everything. A HALT sitting in ID is not accepted until
          // the stall clears.
          fetch_en = 1'b0;
        end else if (id_halt) begin
          // Accept HALT. The PC stays on the HALT address, and the younger
          // instruction already fetched into IF/ID is squashed.
          flush_ifid = 1'b1;
          cnt_d      = DRAIN_LOAD;
          state_d    = ST_DRAIN;
        end else begin
          pc_d = pc_q + PC_STEP;
        end
      end

      ST_DRAIN: begin
        // Only HALT and older instructions remain in flight. Keep IF/ID
        // empty, leave ID/EX alone so the older work can retire, and ignore
        // every control input.
        flush_ifid = 1'b1;
        cnt_d      = cnt_q - 4'd1;
        // The "<=" also covers a counter loaded with 0, so a misconfigured
        // DRAIN_CYC cannot leave the FSM stuck in DRAIN.
        if (cnt_q <= 4'd1) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end
      end

      ST_HALTED: begin
        // Frozen; only reset_n leaves this state.
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= PC_RESET;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign pc           = pc_q;
  assign halted       = halted_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written corner
// sequences, and randomized stimulus checked against a behavioural model.
module tb_pc_sequencer;

  localparam int PC_W  = 9;
  localparam int DRAIN = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            stall;
  logic            ex_redirect;
  logic [PC_W-1:0] ex_target;
  logic            id_halt;
  logic [PC_W-1:0] pc;
  logic            fetch_en;
  logic            flush_ifid;
  logic            flush_idex;
  logic            halted;
  logic            misalign_err;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC(0), .DRAIN_CYC(DRAIN)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_halt     (id_halt),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .halted      (halted),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model. m_age counts cycles since HALT was accepted:
  //   0          running
  //   1..DRAIN   draining
  //   > DRAIN    halted
  int m_pc;
  int m_age;
  bit m_err;

  typedef struct {
    bit              s;
    bit              r;
    logic [PC_W-1:0] t;
    bit              h;
    logic [PC_W-1:0] e_pc;
    bit              e_fe;
    bit              fe_dc;
    bit              e_fi;
    bit              e_fx;
    bit              e_hl;
    bit              e_er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc  = 0;
    m_age = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_advance(input bit s, input bit r,
                                        input logic [PC_W-1:0] t, input bit h);
    logic [1:0] lo;
    lo = t[1:0];
    if (m_age == 0) begin
      if (r) begin
        m_pc = int'(t) & 32'h1FC;
        if (lo != 2'b00) m_err = 1'b1;
      end else if (s) begin
        // PC holds while stalled.
      end else if (h) begin
        m_age = 1;
      end else begin
        m_pc = (m_pc + 4) % (1 << PC_W);
      end
    end else if (m_age <= DRAIN) begin
      m_age++;
    end
  endfunction

  // Drive one cycle's inputs after the falling edge, compare against the
  // model, then advance the model over the next rising edge.
  task automatic step(input bit s, input bit r, input logic [PC_W-1:0] t, input bit h);
    bit run, drn, fe, fi, fx;
    @(negedge clk);
    stall = s; ex_redirect = r; ex_target = t; id_halt = h;
    #1;
    run = (m_age == 0);
    drn = (m_age >= 1) && (m_age <= DRAIN);
    fe  = run && (r || !s);
    fi  = run ? (r || (!s && h)) : drn;
    fx  = run && r;
    chk("pc", int'(pc), m_pc);
    chk("halted", int'(halted), int'(m_age > DRAIN));
    chk("misalign_err", int'(misalign_err), int'(m_err));
    // fetch_en during the HALT-accept cycle is left unconstrained.
    if (!(run && !r && !s && h)) chk("fetch_en", int'(fetch_en), int'(fe));
    chk("flush_ifid", int'(flush_ifid), int'(fi));
    chk("flush_idex", int'(flush_idex), int'(fx));
    $display("cyc s=%0b r=%0b t=0x%03h h=%0b pc=0x%03h fe=%0b fi=%0b fx=%0b hl=%0b er=%0b",
             s, r, t, h, pc, fetch_en, flush_ifid, flush_idex, halted, misalign_err);
    model_advance(s, r, t, h);
  endtask

  // Assert reset mid-cycle, check the asynchronous effect at once, hold it
  // across one rising edge, and release it shortly after that edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    stall = 1'b0; ex_redirect = 1'b0; ex_target = '0; id_halt = 1'b0;
    #1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_misalign", int'(misalign_err), 0);
    chk("rst_fetch_en", int'(fetch_en), 1);
    chk("rst_flush_ifid", int'(flush_ifid), 0);
    chk("rst_flush_idex", int'(flush_idex), 0);
    $display("reset pc=0x%03h fe=%0b hl=%0b er=%0b", pc, fetch_en, halted, misalign_err);
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; stall = 1'b0; ex_redirect = 1'b0; ex_target = '0; id_halt = 1'b0;
    model_reset();

    //                s  r  t       h  pc      fe dc fi fx hl er
    vecs.push_back('{0, 0, 9'h000, 0, 9'h000, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 9'h000, 0, 9'h004, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 9'h000, 0, 9'h008, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 9'h000, 0, 9'h00C, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 9'h040, 0, 9'h010, 1, 1, 1, 1, 0, 0}); // redirect beats stall
    vecs.push_back('{0, 1, 9'h042, 0, 9'h040, 1, 0, 1, 1, 0, 0}); // misaligned target
    vecs.push_back('{0, 0, 9'h000, 0, 9'h040, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 9'h020, 0, 9'h044, 1, 0, 1, 1, 0, 1});
    vecs.push_back('{1, 0, 9'h000, 1, 9'h020, 0, 0, 0, 0, 0, 1}); // stalled HALT
    vecs.push_back('{1, 0, 9'h000, 1, 9'h020, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 0, 9'h000, 1, 9'h020, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 9'h000, 1, 9'h020, 1, 1, 1, 0, 0, 1}); // HALT accepted
    vecs.push_back('{0, 1, 9'h100, 1, 9'h020, 0, 0, 1, 0, 0, 1}); // drain 1
    vecs.push_back('{1, 0, 9'h000, 0, 9'h020, 0, 0, 1, 0, 0, 1}); // drain 2
    vecs.push_back('{0, 0, 9'h000, 0, 9'h020, 0, 0, 1, 0, 0, 1}); // drain 3
    vecs.push_back('{0, 1, 9'h080, 0, 9'h020, 0, 0, 0, 0, 1, 1}); // halted
    vecs.push_back('{0, 0, 9'h000, 1, 9'h020, 0, 0, 0, 0, 1, 1});

    #3;
    apply_reset();

    foreach (vecs[i]) begin
      @(negedge clk);
      stall = vecs[i].s; ex_redirect = vecs[i].r; ex_target = vecs[i].t; id_halt = vecs[i].h;
      #1;
      chk($sformatf("vec%0d_pc", i), int'(pc), int'(vecs[i].e_pc));
      if (!vecs[i].fe_dc) chk($sformatf("vec%0d_fetch_en", i), int'(fetch_en), int'(vecs[i].e_fe));
      chk($sformatf("vec%0d_flush_ifid", i), int'(flush_ifid), int'(vecs[i].e_fi));
      chk($sformatf("vec%0d_flush_idex", i), int'(flush_idex), int'(vecs[i].e_fx));
      chk($sformatf("vec%0d_halted", i), int'(halted), int'(vecs[i].e_hl));
      chk($sformatf("vec%0d_misalign", i), int'(misalign_err), int'(vecs[i].e_er));
      $display("vec%0d pc=0x%03h fe=%0b fi=%0b fx=%0b hl=%0b er=%0b",
               i, pc, fetch_en, flush_ifid, flush_idex, halted, misalign_err);
      model_advance(vecs[i].s, vecs[i].r, vecs[i].t, vecs[i].h);
    end

    // A redirect that coincides with HALT wins; HALT is discarded.
    @(negedge clk);
    apply_reset();
    step(0, 1, 9'h030, 0);
    step(0, 1, 9'h008, 1);
    step(0, 0, 9'h000, 0);
    chk("redir_halt_pc", int'(pc), 9'h008);
    repeat (6) step(0, 0, 9'h000, 0);
    chk("redir_halt_not_halted", int'(halted), 0);
    chk("redir_halt_flush_ifid", int'(flush_ifid), 0);

    // PC wraps from 0x1FC to 0.
    step(0, 1, 9'h1FC, 0);
    step(0, 0, 9'h000, 0);
    step(0, 0, 9'h000, 0);
    chk("wrap_pc", int'(pc), 0);

    // Reset asserted during the second DRAIN cycle.
    @(negedge clk);
    apply_reset();
    step(0, 0, 9'h000, 1);
    step(0, 0, 9'h000, 0);
    step(0, 0, 9'h000, 0);
    chk("drain2_flush_ifid", int'(flush_ifid), 1);
    apply_reset();
    step(0, 0, 9'h000, 0);
    step(0, 0, 9'h000, 0);
    step(0, 0, 9'h000, 0);
    chk("post_reset_pc", int'(pc), 9'h008);
    chk("post_reset_halted", int'(halted), 0);

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      bit s, r, h;
      logic [PC_W-1:0] t;
      if (m_age > DRAIN + 4 || $urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2;
        apply_reset();
      end
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 15) == 0);
      t = PC_W'($urandom_range(0, (1 << PC_W) - 1));
      step(s, r, t, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
